// File: rtl/logic_gate_unit_if.sv
// logic_gate_unit_if: operand/result handshake bundle for logic_gate_unit.
// master = operand producer and result consumer; slave = the unit itself.
interface logic_gate_unit_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_zero;
  logic             out_ones;
  logic [LW-1:0]    level;
  logic [15:0]      op_count;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out, out_zero,
    input  out_ones, level, op_count
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out, out_zero,
    output out_ones, level, op_count
  );
endinterface

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: 8-function bitwise gate feeding a DEPTH-entry result FIFO.
// Ports: clk, rst_n (async low), bus (logic_gate_unit_if.slave).
// Macro LOGIC_GATE_UNIT_COUNT_EN: saturating 16-bit accept counter on op_count.
module logic_gate_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input logic            clk,
  input logic            rst_n,
  logic_gate_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             empty, full, push, pop;
  logic [WIDTH-1:0] res, head;

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL);
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && bus.out_ready;

  always_comb begin
    res = '0;
    unique case (bus.in_op)
      3'd0: res = bus.in_a & bus.in_b;
      3'd1: res = bus.in_a | bus.in_b;
      3'd2: res = bus.in_a ^ bus.in_b;
      3'd3: res = ~(bus.in_a & bus.in_b);
      3'd4: res = ~(bus.in_a | bus.in_b);
      3'd5: res = ~(bus.in_a ^ bus.in_b);
      3'd6: res = ~bus.in_a;
      3'd7: res = bus.in_a;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop)
      level_d = level_q + 1'b1;
    else if (pop && !push)
      level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      level_q <= level_d;
      if (push) begin
        mem_q[wptr_q] <= res;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop)
        rptr_q <= rptr_q + 1'b1;
    end
  end

  // Head is masked while empty so stale entries never leak out.
  assign head          = empty ? '0 : mem_q[rptr_q];
  assign bus.out       = head;
  assign bus.out_valid = !empty;
  assign bus.in_ready  = !full;
  assign bus.out_zero  = !empty && (head == '0);
  assign bus.out_ones  = !empty && (&head);
  assign bus.level     = level_q;

`ifdef LOGIC_GATE_UNIT_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign bus.op_count = cnt_q;
`else
  assign bus.op_count = 16'h0000;
`endif
endmodule
